pipe_bshifter: RTL

- Parametrised, pipelined barrel shifter. Successor to the team's 8-bit combinational rotator.
- Adds:
  - configurable data width;
  - rotate, logical and arithmetic modes;
  - one register per shift stage;
  - valid/ready handshake on both sides with full backpressure.
- Sits between streaming datapath blocks, e.g. ALU operand path or packer. Sustains one result per clock when not stalled.

---
 rtl/pipe_bshifter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_bshifter.sv
// pipe_bshifter: parameterised, pipelined barrel shifter.
//
// Each of the SHW stages shifts by 2^k positions when bit k of the shift
// amount is set, then registers the result together with its sideband
// (amount, direction, mode, original sign bit, valid). All stages share one
// enable, so a stall at the output freezes the whole pipeline.
//
// Parameters:
//   WIDTH  data width, power of 2, >= 4
//   SHW    $clog2(WIDTH): shift-amount width and pipeline depth (derived)
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    input handshake
//   in_data              operand
//   in_amt               shift amount 0..WIDTH-1
//   in_lr                0 = right, 1 = left
//   in_mode              00 rotate, 01 logical, 10 arithmetic, 11 = logical
//   out_valid/out_ready  output handshake
//   out_data             shifted result
//   out_zero             result is all zeros (only with BSH_ZERO_FLAG_EN)
//
// Optional feature macro: BSH_ZERO_FLAG_EN adds the registered out_zero flag.

module pipe_bshifter_stage #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_amt,
    input  logic             i_lr,
    input  logic [1:0]       i_mode,
    input  logic             i_sign,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data,
    output logic [SHW-1:0]   o_amt,
    output logic             o_lr,
    output logic [1:0]       o_mode,
    output logic             o_sign
`ifdef BSH_ZERO_FLAG_EN
    ,
    output logic             o_zero
`endif
);
    localparam int S = 1 << K;
    // Positions vacated by a right shift of S; filled with the sign bit
    // for arithmetic right shifts.
    localparam logic [WIDTH-1:0] HI_MASK = ~({WIDTH{1'b1}} >> S);

    logic [WIDTH-1:0] w_fill;
    logic [WIDTH-1:0] w_nxt;

    logic             r_vld;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_amt;
    logic             r_lr;
    logic [1:0]       r_mode;
    logic             r_sign;

    always_comb begin
        w_fill = '0;
        if (i_mode == 2'b00)
            w_fill = i_lr ? (i_data >> (WIDTH - S)) : (i_data << (WIDTH - S));
        else if (i_mode == 2'b10 && !i_lr && i_sign)
            w_fill = HI_MASK;
        w_nxt = i_data;
        if (i_amt[K])
            w_nxt = (i_lr ? (i_data << S) : (i_data >> S)) | w_fill;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_amt  <= '0;
            r_lr   <= 1'b0;
            r_mode <= '0;
            r_sign <= 1'b0;
        end else if (i_en) begin
            // Bubbles advance too; their data is don't-care downstream.
            r_vld  <= i_vld;
            r_data <= w_nxt;
            r_amt  <= i_amt;
            r_lr   <= i_lr;
            r_mode <= i_mode;
            r_sign <= i_sign;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;
    assign o_amt  = r_amt;
    assign o_lr   = r_lr;
    assign o_mode = r_mode;
    assign o_sign = r_sign;

`ifdef BSH_ZERO_FLAG_EN
    logic r_zero;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_zero <= 1'b0;
        else if (i_en)
            r_zero <= (w_nxt == '0);
    end
    assign o_zero = r_zero;
`endif
endmodule

module pipe_bshifter #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_lr,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef BSH_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);
    // Index 0 is the input side, index k+1 the output of stage k.
    logic [SHW:0]            w_vld_pipe;
    logic [SHW:0][WIDTH-1:0] w_data;
    logic [SHW:0][SHW-1:0]   w_amt;
    logic [SHW:0]            w_lr;
    logic [SHW:0][1:0]       w_mode;
    logic [SHW:0]            w_sign;
    logic                    w_en;

    // Global enable: only a held result at the output stops the pipe.
    assign w_en      = !(w_vld_pipe[SHW] && !out_ready);
    assign in_ready  = w_en;
    assign out_valid = w_vld_pipe[SHW];
    assign out_data  = w_data[SHW];

    assign w_vld_pipe[0] = in_valid;
    assign w_data[0]     = in_data;
    assign w_amt[0]      = in_amt;
    assign w_lr[0]       = in_lr;
    assign w_mode[0]     = in_mode;
    assign w_sign[0]     = in_data[WIDTH-1];

`ifdef BSH_ZERO_FLAG_EN
    logic [SHW-1:0] w_zero;
    logic           w_zero_unused;
    assign out_zero      = w_zero[SHW-1];
    // Only the final stage's flag is observable.
    assign w_zero_unused = ^w_zero[SHW-2:0];
`endif

    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            pipe_bshifter_stage #(
                .WIDTH (WIDTH),
                .SHW   (SHW),
                .K     (k)
            ) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_en   (w_en),
                .i_vld  (w_vld_pipe[k]),
                .i_data (w_data[k]),
                .i_amt  (w_amt[k]),
                .i_lr   (w_lr[k]),
                .i_mode (w_mode[k]),
                .i_sign (w_sign[k]),
                .o_vld  (w_vld_pipe[k+1]),
                .o_data (w_data[k+1]),
                .o_amt  (w_amt[k+1]),
                .o_lr   (w_lr[k+1]),
                .o_mode (w_mode[k+1]),
                .o_sign (w_sign[k+1])
`ifdef BSH_ZERO_FLAG_EN
                ,
                .o_zero (w_zero[k])
`endif
            );
        end
    endgenerate

    // The last stage's sideband has no consumer.
    logic w_unused;
    assign w_unused = ^{w_amt[SHW], w_lr[SHW], w_mode[SHW], w_sign[SHW]};
endmodule
